// File: rtl/muldiv_pkg.sv
// Shared encodings and default width for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_MOD = 2'd2
  } op_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + WIDTH'(1'b1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider/modulo, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_negQ;
  logic             r_negR;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_divZero;
  op_t              w_op;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_zeroResult;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_diff;

  assign w_accept     = (r_state == IDLE) && start && (isMul | isDiv | isMod);
  assign w_op         = isMul ? OP_MUL : (isDiv ? OP_DIV : OP_MOD);
  assign w_divZero    = (w_op != OP_MUL) && (op_b == '0);
  assign w_zeroResult = (w_op == OP_DIV) ? '1 : op_a;

  // r_acc is the partial remainder and r_opA shifts the dividend out / quotient in.
  assign w_remShift = {r_acc, r_opA[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_opB};

  muldiv_signfix #(.WIDTH(WIDTH)) u_absA (.i_val(op_a),  .i_neg(op_a[WIDTH-1]), .o_val(w_absA));
  muldiv_signfix #(.WIDTH(WIDTH)) u_absB (.i_val(op_b),  .i_neg(op_b[WIDTH-1]), .o_val(w_absB));
  muldiv_signfix #(.WIDTH(WIDTH)) u_quot (.i_val(r_opA), .i_neg(r_negQ),        .o_val(w_quot));
  muldiv_signfix #(.WIDTH(WIDTH)) u_rem  (.i_val(r_acc), .i_neg(r_negR),        .o_val(w_rem));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_MUL;
      r_acc       <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            busy    <= 1'b1;
            r_op    <= w_op;
            r_count <= '0;
            r_acc   <= '0;
            if (w_divZero) begin
              result      <= w_zeroResult;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= CALC;
              if (w_op == OP_MUL) begin
                r_opA <= op_a;
                r_opB <= op_b;
              end else begin
                r_opA  <= w_absA;
                r_opB  <= w_absB;
                r_negQ <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                r_negR <= op_a[WIDTH-1];
              end
            end
          end
        end
        CALC: begin
          r_count <= r_count + CW'(1);
          if (r_op == OP_MUL) begin
            if (r_opB[0]) r_acc <= r_acc + r_opA;
            r_opA <= {r_opA[WIDTH-2:0], 1'b0};
            r_opB <= {1'b0, r_opB[WIDTH-1:1]};
          end else if (!w_diff[WIDTH]) begin
            r_acc <= w_diff[WIDTH-1:0];
            r_opA <= {r_opA[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_remShift[WIDTH-1:0];
            r_opA <= {r_opA[WIDTH-2:0], 1'b0};
          end
          if (r_count == LAST_ITER) r_state <= FIX;
        end
        FIX: begin
          case (r_op)
            OP_MUL:  result <= r_acc;
            OP_DIV:  result <= w_quot;
            default: result <= w_rem;
          endcase
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
